// File: rtl/renode_bus_arbiter.sv
// Round-robin bridge from N bus-peripheral request channels to the single Renode message channel.
// Define RENODE_ARB_TIMEOUT_EN to enable the reply timeout and the stale-reply drop.
module renode_bus_arbiter #(
  parameter int ChannelsCount = 4,
  parameter int AddressWidth  = 32,
  parameter int DataWidth     = 64,
  parameter int TimeoutCycles = 1024
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [ChannelsCount-1:0]              req_valid,
  output logic [ChannelsCount-1:0]              req_ready,
  input  logic [ChannelsCount-1:0]              req_write,
  input  logic [2*ChannelsCount-1:0]            req_size,
  input  logic [AddressWidth*ChannelsCount-1:0] req_addr,
  input  logic [DataWidth*ChannelsCount-1:0]    req_data,
  output logic [ChannelsCount-1:0]              rsp_valid,
  output logic [DataWidth-1:0]                  rsp_data,
  output logic                                  rsp_error,
  output logic                                  msg_valid,
  input  logic                                  msg_ready,
  output logic                                  msg_write,
  output logic [1:0]                            msg_size,
  output logic [AddressWidth-1:0]               msg_address,
  output logic [DataWidth-1:0]                  msg_data,
  input  logic                                  reply_valid,
  input  logic                                  reply_error,
  input  logic [DataWidth-1:0]                  reply_data
);
  localparam int         PtrW     = (ChannelsCount > 1) ? $clog2(ChannelsCount) : 1;
  localparam logic [1:0] SizeQuad = 2'd3;
  localparam bit         QuadOk   = (DataWidth == 64);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;
  state_t state, state_nxt;

  logic [PtrW-1:0]         rr_ptr, rr_nxt, gnt_idx, cur_idx, scan_idx;
  logic                    gnt_found, size_illegal, reply_take, timeout_hit;
  logic                    g_write;
  logic [1:0]              g_size;
  logic [AddressWidth-1:0] g_addr;
  logic [DataWidth-1:0]    g_data;

  // First requesting channel at or after the round-robin pointer, plus its fields.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    g_write   = 1'b0;
    g_size    = '0;
    g_addr    = '0;
    g_data    = '0;
    for (int i = 0; i < ChannelsCount; i++) begin
      scan_idx = PtrW'((int'(rr_ptr) + i) % ChannelsCount);
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
    for (int i = 0; i < ChannelsCount; i++) begin
      if (gnt_idx == PtrW'(i)) begin
        g_write = req_write[i];
        g_size  = req_size[2*i +: 2];
        g_addr  = req_addr[AddressWidth*i +: AddressWidth];
        g_data  = req_data[DataWidth*i +: DataWidth];
      end
    end
  end

  assign size_illegal = !QuadOk && (g_size == SizeQuad);
  assign rr_nxt       = (gnt_idx == PtrW'(ChannelsCount - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    case (state)
      ST_IDLE:  if (gnt_found) state_nxt = size_illegal ? ST_RESP : ST_ISSUE;
      ST_ISSUE: if (msg_ready) state_nxt = ST_WAIT;
      ST_WAIT:  if (reply_take || timeout_hit) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    // Channels may keep requesting through reset; the accept pulse must stay low then.
    for (int i = 0; i < ChannelsCount; i++) begin
      req_ready[i] = rst_n && (state == ST_IDLE) && gnt_found && (gnt_idx == PtrW'(i));
      rsp_valid[i] = (state == ST_RESP) && (cur_idx == PtrW'(i));
    end
  end

  assign msg_valid = (state == ST_ISSUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      cur_idx     <= '0;
      msg_write   <= 1'b0;
      msg_size    <= '0;
      msg_address <= '0;
      msg_data    <= '0;
      rsp_data    <= '0;
      rsp_error   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
      state <= state_nxt;
      if (state == ST_IDLE && gnt_found) begin
        cur_idx     <= gnt_idx;
        rr_ptr      <= rr_nxt;
        msg_write   <= g_write;
        msg_size    <= g_size;
        msg_address <= g_addr;
        msg_data    <= g_write ? g_data : '0;
        if (size_illegal) begin
          rsp_data  <= '0;
          rsp_error <= 1'b1;
        end
      end
      if (state == ST_WAIT) begin
        if (reply_take) begin
          rsp_data  <= msg_write ? '0 : reply_data;
          rsp_error <= reply_error;
        end else if (timeout_hit) begin
          rsp_data  <= '0;
          rsp_error <= 1'b1;
        end
      end
    end
  end

`ifdef RENODE_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TimeoutCycles);

  logic [TW-1:0] wait_cnt;
  logic          stale;

  // A reply arriving after its transaction timed out belongs to nobody and is swallowed once.
  assign reply_take  = reply_valid && !stale;
  assign timeout_hit = (state == ST_WAIT) && (wait_cnt == TW'(TimeoutCycles - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      stale    <= 1'b0;
    end else begin
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
      if (state == ST_WAIT && timeout_hit && !reply_take) stale <= 1'b1;
      else if (stale && reply_valid)                      stale <= 1'b0;
    end
  end
`else
  assign reply_take  = reply_valid;
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_renode_bus_arbiter.sv
// Self-checking bench for renode_bus_arbiter: vector table, scoreboard of responses, corner sequences.
module tb_renode_bus_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, req_write, rsp_valid;
  logic [2*N-1:0]  req_size;
  logic [AW*N-1:0] req_addr;
  logic [DW*N-1:0] req_data;
  logic [DW-1:0]   rsp_data, msg_data, reply_data;
  logic            rsp_error, msg_valid, msg_ready, msg_write, reply_valid, reply_error;
  logic [1:0]      msg_size;
  logic [AW-1:0]   msg_address;

  // Second instance, 32-bit data, for the illegal QuadWord path.
  logic [N-1:0]    d_req_valid, d_req_ready, d_req_write, d_rsp_valid;
  logic [2*N-1:0]  d_req_size;
  logic [AW*N-1:0] d_req_addr;
  logic [32*N-1:0] d_req_data;
  logic [31:0]     d_rsp_data, d_msg_data, d_reply_data;
  logic            d_rsp_error, d_msg_valid, d_msg_write;
  logic [1:0]      d_msg_size;
  logic [AW-1:0]   d_msg_address;

  renode_bus_arbiter #(.ChannelsCount(N), .AddressWidth(AW), .DataWidth(DW), .TimeoutCycles(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_data(req_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_error(rsp_error), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_write(msg_write), .msg_size(msg_size), .msg_address(msg_address), .msg_data(msg_data),
    .reply_valid(reply_valid), .reply_error(reply_error), .reply_data(reply_data)
  );

  renode_bus_arbiter #(.ChannelsCount(N), .AddressWidth(AW), .DataWidth(32), .TimeoutCycles(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .req_valid(d_req_valid), .req_ready(d_req_ready), .req_write(d_req_write),
    .req_size(d_req_size), .req_addr(d_req_addr), .req_data(d_req_data), .rsp_valid(d_rsp_valid),
    .rsp_data(d_rsp_data), .rsp_error(d_rsp_error), .msg_valid(d_msg_valid), .msg_ready(1'b1),
    .msg_write(d_msg_write), .msg_size(d_msg_size), .msg_address(d_msg_address), .msg_data(d_msg_data),
    .reply_valid(1'b0), .reply_error(1'b0), .reply_data(d_reply_data)
  );

  typedef struct {
    int          ch;
    logic [63:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    int          ch;
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        rerr;
    logic [63:0] exp_rsp;
    logic        exp_err;
    logic [63:0] exp_msg_data;
  } vec_t;

  exp_t        sb[$];
  int          gnt_log[$];
  int          total = 0, bad = 0;
  int          cyc = 0, gnt_cyc = 0, rsp_cyc = 0, msg_count = 0, rsp_seen = 0;
  logic        auto_reply;
  logic [63:0] cur_reply_data;
  logic        cur_reply_err;
  logic        m_write;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [63:0] m_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic push_exp(input int ch, input logic [63:0] data, input logic err);
    exp_t e;
    e.ch = ch; e.data = data; e.err = err;
    sb.push_back(e);
  endtask

  task automatic launch(input int ch, input logic wr, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [63:0] wd);
    req_valid[ch]          = 1'b1;
    req_write[ch]          = wr;
    req_size[2*ch +: 2]    = sz;
    req_addr[AW*ch +: AW]  = addr;
    req_data[DW*ch +: DW]  = wd;
  endtask

  // One clock: sample at the falling edge, then act as channel adapters and Renode just after the rise.
  task automatic cycle();
    logic         xfer;
    logic [N-1:0] g;
    exp_t         e;
    @(negedge clk);
    xfer = msg_valid && msg_ready;
    g    = req_ready;
    if (xfer) begin
      msg_count++;
      m_write = msg_write; m_size = msg_size; m_addr = msg_address; m_data = msg_data;
    end
    if (g != '0) begin
      check("grant_onehot", 64'($onehot(g)), 64'd1);
      gnt_log.push_back(onehot_idx(g));
      gnt_cyc = cyc;
    end
    if (rsp_valid != '0) begin
      rsp_seen++;
      rsp_cyc = cyc;
      if (sb.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_channel", 64'(rsp_valid), 64'(4'b0001 << e.ch));
        check("rsp_data", rsp_data, e.data);
        check("rsp_error", 64'(rsp_error), 64'(e.err));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    req_valid   = req_valid & ~g;
    reply_valid = xfer && auto_reply;
    reply_data  = cur_reply_data;
    reply_error = cur_reply_err;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_budget", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    int   mc0, rs0, held, n;
    int   exp_order[5];
    logic reraised;

    vecs[0] = '{0, 1'b0, 2'd2, 32'h0000_1000, 64'h0, 64'hCAFE_BABE, 1'b0, 64'hCAFE_BABE, 1'b0, 64'h0};
    vecs[1] = '{1, 1'b1, 2'd1, 32'h0000_2002, 64'hBEEF, 64'h1111, 1'b0, 64'h0, 1'b0, 64'hBEEF};
    vecs[2] = '{3, 1'b0, 2'd3, 32'hFFFF_FFF8, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0,
                64'h0123_4567_89AB_CDEF, 1'b0, 64'h0};
    vecs[3] = '{2, 1'b0, 2'd0, 32'h0000_0000, 64'h0, 64'hAB, 1'b1, 64'hAB, 1'b1, 64'h0};
    vecs[4] = '{0, 1'b1, 2'd3, 32'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h22, 1'b1, 64'h0, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF};
    vecs[5] = '{1, 1'b0, 2'd2, 32'h0000_1004, 64'hDEAD, 64'h5A, 1'b0, 64'h5A, 1'b0, 64'h0};
    exp_order = '{0, 1, 2, 3, 0};

    rst_n = 1'b0;
    req_valid = '0; req_write = '0; req_size = '0; req_addr = '0; req_data = '0;
    msg_ready = 1'b1; reply_valid = 1'b0; reply_error = 1'b0; reply_data = '0;
    auto_reply = 1'b1; cur_reply_data = '0; cur_reply_err = 1'b0;
    d_req_valid = '0; d_req_write = '0; d_req_size = '0; d_req_addr = '0; d_req_data = '0;
    d_reply_data = '0;

    // Reset state, with every channel requesting.
    req_valid = '1;
    #1;
    check("reset_ctrl", 64'({req_ready, rsp_valid, msg_valid, msg_write, msg_size, rsp_error}), 64'd0);
    check("reset_addr", 64'(msg_address), 64'd0);
    check("reset_msg_data", msg_data, 64'd0);
    check("reset_rsp_data", rsp_data, 64'd0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single transactions from the vector table.
    for (int i = 0; i < 6; i++) begin
      cur_reply_data = vecs[i].rdata;
      cur_reply_err  = vecs[i].rerr;
      mc0 = msg_count;
      launch(vecs[i].ch, vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].wdata);
      push_exp(vecs[i].ch, vecs[i].exp_rsp, vecs[i].exp_err);
      drain(20);
      check("msg_count", 64'(msg_count - mc0), 64'd1);
      check("msg_write", 64'(m_write), 64'(vecs[i].wr));
      check("msg_size", 64'(m_size), 64'(vecs[i].sz));
      check("msg_address", 64'(m_addr), 64'(vecs[i].addr));
      check("msg_data", m_data, vecs[i].exp_msg_data);
      check("latency", 64'(rsp_cyc - gnt_cyc), 64'd3);
    end
    check("rsp_hold_valid", 64'(rsp_valid), 64'd0);
    check("rsp_hold_data", rsp_data, 64'h5A);

    // QuadWord on the 32-bit instance: rejected without a message.
    d_req_size[3:2]   = 2'd3;
    d_req_addr[63:32] = 32'h50;
    d_req_valid       = 4'b0010;
    #1;
    check("d32_ready", 64'(d_req_ready), 64'b0010);
    check("d32_no_msg_grant", 64'(d_msg_valid), 64'd0);
    cycle();
    d_req_valid = '0;
    check("d32_rsp_valid", 64'(d_rsp_valid), 64'b0010);
    check("d32_rsp_error", 64'(d_rsp_error), 64'd1);
    check("d32_rsp_data", 64'(d_rsp_data), 64'd0);
    check("d32_no_msg_resp", 64'(d_msg_valid), 64'd0);
    cycle();
    check("d32_idle", 64'({d_rsp_valid, d_msg_valid}), 64'd0);

    // Reset during WAIT: everything clears at once, the aborted request never responds.
    auto_reply = 1'b0;
    launch(1, 1'b0, 2'd2, 32'h3000, 64'h0);
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    req_valid = 4'b1010;
    #1;
    check("midrst_ctrl", 64'({req_ready, rsp_valid, msg_valid, msg_write, msg_size, rsp_error}), 64'd0);
    check("midrst_addr", 64'(msg_address), 64'd0);
    check("midrst_rsp_data", rsp_data, 64'd0);
    req_valid = '0;
    rs0 = rsp_seen;
    mc0 = msg_count;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    reply_valid = 1'b1; reply_data = 64'h99;
    cycle();
    cycle();
    cycle();
    check("midrst_no_rsp", 64'(rsp_seen - rs0), 64'd0);
    check("midrst_no_msg", 64'(msg_count - mc0), 64'd0);
    auto_reply = 1'b1;
    cur_reply_data = 64'h3;
    cur_reply_err  = 1'b0;
    gnt_log.delete();
    launch(1, 1'b1, 2'd2, 32'h3010, 64'h1);
    launch(3, 1'b1, 2'd2, 32'h3030, 64'h3);
    push_exp(1, 64'h0, 1'b0);
    push_exp(3, 64'h0, 1'b0);
    drain(30);
    check("postrst_first", 64'(gnt_log.size() > 0 ? gnt_log[0] : -1), 64'd1);
    check("postrst_second", 64'(gnt_log.size() > 1 ? gnt_log[1] : -1), 64'd3);

    // All channels at once; ch0 asks again right after its grant and must wait its turn.
    gnt_log.delete();
    for (int c = 0; c < N; c++) begin
      launch(c, 1'b1, 2'd2, 32'(32'h100 * c), 64'(c + 1));
      push_exp(c, 64'h0, 1'b0);
    end
    push_exp(0, 64'h0, 1'b0);
    reraised = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      cycle();
      n++;
      if (!reraised && gnt_log.size() >= 1) begin
        launch(0, 1'b1, 2'd2, 32'h500, 64'h7);
        reraised = 1'b1;
      end
    end
    check("order_budget", 64'(sb.size()), 64'd0);
    sb.delete();
    check("order_count", 64'(gnt_log.size()), 64'd5);
    for (int k = 0; k < 5; k++)
      check("grant_order", 64'(gnt_log.size() > k ? gnt_log[k] : -1), 64'(exp_order[k]));

    // ch2 write Byte 0x55 @0x20 with Renode stalling for 5 cycles.
    msg_ready = 1'b0;
    mc0 = msg_count;
    launch(2, 1'b1, 2'd0, 32'h20, 64'h55);
    push_exp(2, 64'h0, 1'b0);
    cycle();
    held = 0;
    for (int k = 0; k < 5; k++) begin
      if (msg_valid && msg_write && msg_size == 2'd0 && msg_address == 32'h20 && msg_data == 64'h55)
        held++;
      cycle();
    end
    check("stall_held", 64'(held), 64'd5);
    check("stall_still_valid", 64'(msg_valid), 64'd1);
    msg_ready = 1'b1;
    drain(10);
    check("stall_one_msg", 64'(msg_count - mc0), 64'd1);
    check("stall_latency", 64'(rsp_cyc - gnt_cyc), 64'd8);

`ifdef RENODE_ARB_TIMEOUT_EN
    // No reply: error after 8 WAIT cycles; the late reply is swallowed during the next transaction.
    auto_reply = 1'b0;
    launch(0, 1'b0, 2'd2, 32'h4000, 64'h0);
    push_exp(0, 64'h0, 1'b1);
    drain(20);
    check("timeout_latency", 64'(rsp_cyc - gnt_cyc), 64'd10);
    launch(2, 1'b0, 2'd2, 32'h4008, 64'h0);
    push_exp(2, 64'h1234, 1'b0);
    cycle();
    cycle();
    reply_valid = 1'b1; reply_data = 64'hDEAD; reply_error = 1'b1;
    cycle();
    cycle();
    reply_valid = 1'b1; reply_data = 64'h1234; reply_error = 1'b0;
    drain(5);
`else
    // Without the timeout, WAIT holds until the reply arrives.
    auto_reply = 1'b0;
    rs0 = rsp_seen;
    launch(0, 1'b0, 2'd1, 32'h40, 64'h0);
    push_exp(0, 64'h77, 1'b0);
    cycle();
    cycle();
    for (int k = 0; k < 20; k++) cycle();
    check("wait_hold_no_rsp", 64'(rsp_seen - rs0), 64'd0);
    reply_valid = 1'b1; reply_data = 64'h77; reply_error = 1'b0;
    drain(5);
    check("wait_hold_rsp", 64'(rsp_seen - rs0), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
